// File: rtl/pipelined_log_multiplier.sv
// Three-stage pipelined signed multiplier offering an exact product or a
// Mitchell-style logarithmic approximation with dynamic mantissa truncation.
// Each transaction carries its own mode bit, so exact and approximate
// requests can be freely interleaved in one stream. All stages advance
// together, so a stalled output freezes the whole pipeline.
module pipelined_log_multiplier #(
    parameter int WIDTH = 8,
    parameter int T     = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic signed [WIDTH-1:0]   A,
    input  logic signed [WIDTH-1:0]   B,
    input  logic                      approx_en,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic signed [2*WIDTH-1:0] result
);

    localparam int KW  = $clog2(WIDTH);
    localparam int PW  = 2 * WIDTH;
    localparam int SHW = PW + T + 2;

    // Magnitude in WIDTH unsigned bits; the most negative input maps to 2^(WIDTH-1)
    function automatic logic [WIDTH-1:0] absVal(input logic [WIDTH-1:0] v);
        absVal = v[WIDTH-1] ? (~v + WIDTH'(1)) : v;
    endfunction

    // Position of the highest set bit; zero input yields 0 and is masked later
    function automatic logic [KW-1:0] leadingOne(input logic [WIDTH-1:0] v);
        leadingOne = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (v[i]) leadingOne = KW'(i);
        end
    endfunction

    // Top T-2 fraction bits below the leading one, with a forced trailing 1
    // that centres the truncation error of the discarded bits
    function automatic logic [T-2:0] truncMant(input logic [WIDTH-1:0] v,
                                               input logic [KW-1:0]    k);
        logic [WIDTH-1:0] aligned;
        logic [T-3:0]     top;
        aligned = v << (KW'(WIDTH-1) - k);
        top     = (T-2)'(aligned >> (WIDTH-T+1));
        truncMant = {top, 1'b1};
    endfunction

    logic en;
    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    // Stage 1 next-state: signs, magnitudes and the log encoding of each operand
    logic [WIDTH-1:0] magA_d, magB_d;
    logic [KW-1:0]    kA_d, kB_d;
    logic [T-2:0]     xtA_d, xtB_d;
    logic             sign1_d, zero1_d;

    // Decode operands into sign, zero flag, magnitude and (k, x_t) log pairs
    always_comb begin
        magA_d  = absVal(A);
        magB_d  = absVal(B);
        kA_d    = leadingOne(magA_d);
        kB_d    = leadingOne(magB_d);
        xtA_d   = truncMant(magA_d, kA_d);
        xtB_d   = truncMant(magB_d, kB_d);
        sign1_d = A[WIDTH-1] ^ B[WIDTH-1];
        zero1_d = (magA_d == '0) || (magB_d == '0);
    end

    logic             v1_q, sign1_q, zero1_q, mode1_q;
    logic [WIDTH-1:0] magA1_q, magB1_q;
    logic [KW-1:0]    kA1_q, kB1_q;
    logic [T-2:0]     xtA1_q, xtB1_q;

    // Stage 1 register; an idle input cycle advances as a bubble
    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q    <= 1'b0;
            sign1_q <= 1'b0;
            zero1_q <= 1'b0;
            mode1_q <= 1'b0;
            magA1_q <= '0;
            magB1_q <= '0;
            kA1_q   <= '0;
            kB1_q   <= '0;
            xtA1_q  <= '0;
            xtB1_q  <= '0;
        end else if (en) begin
            v1_q    <= in_valid;
            sign1_q <= sign1_d;
            zero1_q <= zero1_d;
            mode1_q <= approx_en;
            magA1_q <= magA_d;
            magB1_q <= magB_d;
            kA1_q   <= kA_d;
            kB1_q   <= kB_d;
            xtA1_q  <= xtA_d;
            xtB1_q  <= xtB_d;
        end
    end

    // Stage 2 next-state: log-domain sum and the exact magnitude product
    logic [KW:0]   kSum_d;
    logic [T-1:0]  mSum_d;
    logic [PW-1:0] prod_d;

    // Add exponents and truncated mantissas; exact product computed alongside
    always_comb begin
        kSum_d = {1'b0, kA1_q} + {1'b0, kB1_q};
        mSum_d = {1'b0, xtA1_q} + {1'b0, xtB1_q};
        prod_d = PW'(magA1_q) * PW'(magB1_q);
    end

    logic          v2_q, sign2_q, zero2_q, mode2_q;
    logic [KW:0]   kSum2_q;
    logic [T-1:0]  mSum2_q;
    logic [PW-1:0] prod2_q;

    // Stage 2 register carrying sum/product plus the per-transaction mode
    always_ff @(posedge clk) begin
        if (rst) begin
            v2_q    <= 1'b0;
            sign2_q <= 1'b0;
            zero2_q <= 1'b0;
            mode2_q <= 1'b0;
            kSum2_q <= '0;
            mSum2_q <= '0;
            prod2_q <= '0;
        end else if (en) begin
            v2_q    <= v1_q;
            sign2_q <= sign1_q;
            zero2_q <= zero1_q;
            mode2_q <= mode1_q;
            kSum2_q <= kSum_d;
            mSum2_q <= mSum_d;
            prod2_q <= prod_d;
        end
    end

    // Stage 3 next-state: antilog, mode select, sign and zero forcing
    logic [SHW-1:0]       shifted;
    logic [PW-1:0]        approxMag, magSel;
    logic signed [PW-1:0] result_d;

    // A mantissa sum that carries past 1.0 bumps the exponent by one instead
    // of adding the implicit leading one
    always_comb begin
        if (!mSum2_q[T-1]) begin
            shifted = SHW'({1'b1, mSum2_q[T-2:0]}) << kSum2_q;
        end else begin
            shifted = SHW'(mSum2_q) << (kSum2_q + 1'b1);
        end
        approxMag = PW'(shifted >> (T-1));
        magSel    = mode2_q ? approxMag : prod2_q;
        if (zero2_q) begin
            result_d = '0;
        end else if (sign2_q) begin
            result_d = -magSel;
        end else begin
            result_d = magSel;
        end
    end

    logic                 v3_q;
    logic signed [PW-1:0] result_q;

    // Output register; holds the presented result while downstream stalls
    always_ff @(posedge clk) begin
        if (rst) begin
            v3_q     <= 1'b0;
            result_q <= '0;
        end else if (en) begin
            v3_q     <= v2_q;
            result_q <= result_d;
        end
    end

    assign out_valid = v3_q;
    assign result    = result_q;

endmodule

// File: tb/tb_pipelined_log_multiplier.sv
// Self-checking bench for pipelined_log_multiplier: directed vectors with
// hand-computed products, a backpressure stream, reset mid-stream, and a
// random stream checked by a scoreboard against an independent model.
module tb_pipelined_log_multiplier;

    localparam int W  = 8;
    localparam int TT = 4;

    logic                  clk;
    logic                  rst;
    logic                  inValid;
    logic                  inReady;
    logic signed [W-1:0]   a;
    logic signed [W-1:0]   b;
    logic                  approxEn;
    logic                  outValid;
    logic                  outReady;
    logic signed [2*W-1:0] result;

    int checkCount = 0;
    int failCount  = 0;
    int outCount   = 0;
    longint expQ[$];

    pipelined_log_multiplier #(.WIDTH(W), .T(TT)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (inValid),
        .in_ready  (inReady),
        .A         (a),
        .B         (b),
        .approx_en (approxEn),
        .out_valid (outValid),
        .out_ready (outReady),
        .result    (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input longint observed, input longint expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference product built from the leading-one / truncation definition
    function automatic longint refModel(input longint x, input longint y, input bit mode);
        longint mx, my, p;
        int kx, ky, fx, fy, s, kk, half;
        logic signed [2*W-1:0] trunc;
        if (x == 0 || y == 0) return 0;
        mx = (x < 0) ? -x : x;
        my = (y < 0) ? -y : y;
        kx = 0;
        while ((mx >> (kx + 1)) != 0) kx++;
        ky = 0;
        while ((my >> (ky + 1)) != 0) ky++;
        fx = int'((((mx - (longint'(1) << kx)) << (W - 1 - kx)) >> (W - 1 - (TT - 2)))) * 2 + 1;
        fy = int'((((my - (longint'(1) << ky)) << (W - 1 - ky)) >> (W - 1 - (TT - 2)))) * 2 + 1;
        half = 1 << (TT - 1);
        if (mode) begin
            s  = fx + fy;
            kk = kx + ky;
            if (s < half) p = (longint'(half + s) << kk) >> (TT - 1);
            else          p = (longint'(s) << (kk + 1)) >> (TT - 1);
        end else begin
            p = mx * my;
        end
        if ((x < 0) != (y < 0)) p = -p;
        trunc = p[2*W-1:0];
        return longint'(trunc);
    endfunction

    // Scoreboard: expected values queued at input transfer, compared at output transfer
    always @(negedge clk) begin
        if (rst) begin
            expQ.delete();
        end else begin
            if (outValid && outReady) begin
                if (expQ.size() == 0) begin
                    checkOutput("sb_unexpected_out", 1, 0);
                end else begin
                    checkOutput("sb_result", longint'(result), expQ.pop_front());
                    outCount++;
                end
            end
            if (inValid && inReady) expQ.push_back(refModel(longint'(a), longint'(b), approxEn));
        end
    end

    // Single transaction with out_ready held high; checks the 3-cycle latency
    task automatic applyStimulus(input string tag, input int x, input int y,
                                 input bit mode, input longint expected);
        outReady = 1'b1;
        inValid  = 1'b1;
        a        = W'(x);
        b        = W'(y);
        approxEn = mode;
        tick();
        inValid = 1'b0;
        checkOutput({tag, "_lat1"}, longint'(outValid), 0);
        tick();
        checkOutput({tag, "_lat2"}, longint'(outValid), 0);
        tick();
        checkOutput({tag, "_valid"}, longint'(outValid), 1);
        checkOutput(tag, longint'(result), expected);
    endtask

    int bpA[6] = '{3, 3, -4, 7, -128, 127};
    int bpB[6] = '{5, -5, 4, 9, -128, 127};
    bit bpM[6] = '{1, 0, 1, 0, 0, 1};

    initial begin
        int idx;
        int startCount;
        bit accepted;
        rst = 1'b1; inValid = 1'b0; a = '0; b = '0; approxEn = 1'b0; outReady = 1'b0;
        repeat (3) tick();
        checkOutput("reset_out_valid", longint'(outValid), 0);
        checkOutput("reset_result", longint'(result), 0);
        checkOutput("reset_in_ready", longint'(inReady), 1);
        rst = 1'b0;
        tick();
        checkOutput("post_reset_in_ready", longint'(inReady), 1);

        applyStimulus("approx_3x5", 3, 5, 1'b1, 16);
        applyStimulus("exact_3xm5", 3, -5, 1'b0, -15);
        applyStimulus("approx_m4x4", -4, 4, 1'b1, -20);
        applyStimulus("approx_0xm128", 0, -128, 1'b1, 0);
        applyStimulus("exact_0xm128", 0, -128, 1'b0, 0);
        applyStimulus("exact_m128xm128", -128, -128, 1'b0, 16384);
        applyStimulus("approx_m128xm128", -128, -128, 1'b1, 20480);
        applyStimulus("approx_127x127", 127, 127, 1'b1, 14336);
        applyStimulus("exact_127xm1", 127, -1, 1'b0, -127);
        tick();

        // Backpressure: six back-to-back pairs, output stalled in cycles 4..7
        idx = 0;
        startCount = outCount;
        for (int c = 1; c <= 30; c++) begin
            outReady = !(c >= 4 && c <= 7);
            if (idx < 6) begin
                inValid  = 1'b1;
                a        = W'(bpA[idx]);
                b        = W'(bpB[idx]);
                approxEn = bpM[idx];
            end else begin
                inValid = 1'b0;
            end
            #1;
            accepted = inValid && inReady;
            if (c >= 4 && c <= 7) begin
                checkOutput("bp_in_ready_stalled", longint'(inReady), 0);
                checkOutput("bp_out_valid_stalled", longint'(outValid), 1);
                checkOutput("bp_result_held", longint'(result), 16);
            end
            tick();
            if (accepted) idx++;
        end
        checkOutput("bp_all_accepted", idx, 6);
        checkOutput("bp_all_delivered", outCount - startCount, 6);
        checkOutput("bp_queue_empty", expQ.size(), 0);

        // Reset with three transactions occupying all stages
        outReady = 1'b0;
        for (int i = 0; i < 3; i++) begin
            inValid = 1'b1; a = W'(i + 2); b = W'(-(i + 3)); approxEn = i[0];
            tick();
        end
        inValid = 1'b0;
        checkOutput("rst_full_before", longint'(outValid), 1);
        rst = 1'b1;
        tick();
        checkOutput("rst_mid_out_valid", longint'(outValid), 0);
        checkOutput("rst_mid_result", longint'(result), 0);
        rst = 1'b0;
        outReady = 1'b1;
        checkOutput("rst_mid_in_ready", longint'(inReady), 1);
        for (int i = 0; i < 6; i++) begin
            tick();
            checkOutput("rst_no_ghost", longint'(outValid), 0);
        end
        applyStimulus("post_rst_exact_6x7", 6, 7, 1'b0, 42);
        tick();

        // Random mixed-mode stream with random backpressure
        for (int i = 0; i < 10000; i++) begin
            inValid  = ($urandom_range(0, 4) != 0);
            a        = W'($urandom_range(0, 255));
            b        = W'($urandom_range(0, 255));
            approxEn = $urandom_range(0, 1) == 1;
            outReady = ($urandom_range(0, 3) != 0);
            tick();
        end
        inValid  = 1'b0;
        outReady = 1'b1;
        repeat (6) tick();
        checkOutput("rand_drain_empty", expQ.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
